// File: rtl/test_bus.sv
// Shared-bus interconnect: round-robin arbitration over device FIFO heads and
// routing of one packet at a time by the 8-bit destination ID in its top byte.
module test_bus #(
    parameter int          WIDTH        = 16,
    parameter int          DISPOSITIVOS = 16,
    parameter logic [7:0]  BROADCAST    = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [DISPOSITIVOS-1:0]                  pndng,
    input  logic [DISPOSITIVOS-1:0][WIDTH-1:0]       D_pop,
    output logic [DISPOSITIVOS-1:0]                  pop,
    output logic [DISPOSITIVOS-1:0]                  push,
    output logic [WIDTH-1:0]                         D_push
);

    localparam int IDW = (DISPOSITIVOS > 1) ? $clog2(DISPOSITIVOS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_q, rr_d;
    logic [IDW-1:0]          src_q, src_d;
    logic [IDW-1:0]          sel_idx;
    logic                    sel_found;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [DISPOSITIVOS-1:0] pop_q, pop_d;
    logic [DISPOSITIVOS-1:0] push_q, push_d;
    logic [DISPOSITIVOS-1:0] dst_hit;
    logic [WIDTH-1:0]        head;
    logic [7:0]              dst_id;
    int                      cand;

    assign head   = D_pop[src_q];
    assign dst_id = head[WIDTH-1 -: 8];

    // Broadcast reaches everyone but the sender; IDs at or above the device
    // count match no bit, so such packets are dropped.
    generate
        for (genvar gi = 0; gi < DISPOSITIVOS; gi++) begin : g_dst
            assign dst_hit[gi] = (dst_id == BROADCAST) ? (src_q != IDW'(gi))
                                                       : (dst_id == 8'(gi));
        end
    endgenerate

    // First pending device at or above rr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < DISPOSITIVOS; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= DISPOSITIVOS) cand = cand - DISPOSITIVOS;
            if (!sel_found && pndng[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        data_d  = data_q;
        pop_d   = '0;
        push_d  = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    src_d          = sel_idx;
                    pop_d[sel_idx] = 1'b1;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                data_d  = head;
                rr_d    = (src_q == IDW'(DISPOSITIVOS - 1)) ? '0 : src_q + 1'b1;
                push_d  = dst_hit;
                state_d = DELIVER;
            end
            DELIVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            src_q   <= '0;
            data_q  <= '0;
            pop_q   <= '0;
            push_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
        end
    end

    assign pop    = pop_q;
    assign push   = push_q;
    assign D_push = data_q;

endmodule

// File: tb/tb_test_bus.sv
// Directed self-checking bench for test_bus: reset, unicast, broadcast,
// dropped packet, round-robin order and reset in the middle of a transfer.
module tb_test_bus;

    logic              clk;
    logic              reset;
    logic [15:0]       pndng;
    logic [15:0][15:0] d_pop;
    logic [15:0]       pop;
    logic [15:0]       push;
    logic [15:0]       d_push;

    int total_cnt;
    int pass_cnt;

    test_bus #(
        .WIDTH       (16),
        .DISPOSITIVOS(16),
        .BROADCAST   (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pndng (pndng),
        .D_pop (d_pop),
        .pop   (pop),
        .push  (push),
        .D_push(d_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %s ok: %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin table: pndng = 8011 held, one entry per cycle after the first grant edge.
    logic [15:0] rr_pop_exp  [12];
    logic [15:0] rr_push_exp [12];
    logic [15:0] rr_data_exp [12];

    initial begin
        rr_pop_exp  = '{16'h0001, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000,
                        16'h8000, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
        rr_push_exp = '{16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0020, 16'h0000,
                        16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0002, 16'h0000};
        rr_data_exp = '{16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0500, 16'h0000,
                        16'h0000, 16'hFF00, 16'h0000, 16'h0000, 16'h0100, 16'h0000};
        total_cnt = 0;
        pass_cnt  = 0;
        reset     = 1'b1;
        pndng     = 16'hFFFF;
        d_pop     = '0;
        for (int i = 0; i < 16; i++) d_pop[i] = 16'h2000 | 16'(i);
        d_pop[0] = 16'h0900;

        // Reset held two cycles with every device requesting
        tick();
        check("rst1_pop", pop, 16'h0000);
        check("rst1_push", push, 16'h0000);
        tick();
        check("rst2_pop", pop, 16'h0000);
        check("rst2_push", push, 16'h0000);
        check("rst2_dpush", d_push, 16'h0000);
        reset = 1'b0;
        tick();
        check("first_grant", pop, 16'h0001);
        pndng = 16'h0000;
        tick();
        check("first_push", push, 16'h0200);
        check("first_dpush", d_push, 16'h0900);
        check("first_nopop", pop, 16'h0000);
        tick();
        check("first_idle", push, 16'h0000);

        // Unicast from device 3 to device 5
        d_pop[3] = 16'h05AB;
        pndng    = 16'h0008;
        tick();
        check("uni_pop", pop, 16'h0008);
        check("uni_nopush", push, 16'h0000);
        pndng = 16'h0000;
        tick();
        check("uni_push", push, 16'h0020);
        check("uni_dpush", d_push, 16'h05AB);
        check("uni_nopop", pop, 16'h0000);
        tick();
        check("uni_end_push", push, 16'h0000);
        check("uni_hold", d_push, 16'h05AB);

        // Broadcast from device 7
        d_pop[7] = 16'hFF12;
        pndng    = 16'h0080;
        tick();
        check("bc_pop", pop, 16'h0080);
        pndng = 16'h0000;
        tick();
        check("bc_push", push, 16'hFF7F);
        check("bc_dpush", d_push, 16'hFF12);
        tick();
        check("bc_end_push", push, 16'h0000);

        // Destination 0x20 does not exist: popped but dropped
        d_pop[2] = 16'h2034;
        pndng    = 16'h0004;
        tick();
        check("inv_pop", pop, 16'h0004);
        pndng = 16'h0000;
        tick();
        check("inv_push", push, 16'h0000);
        check("inv_nopop", pop, 16'h0000);
        tick();
        check("inv_idle_pop", pop, 16'h0000);
        check("inv_idle_push", push, 16'h0000);

        // Round-robin among devices 0, 4, 15 starting from rr = 0
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        d_pop[0]  = 16'h0100;
        d_pop[4]  = 16'h0500;
        d_pop[15] = 16'hFF00;
        pndng     = 16'h8011;
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("rr%0d_pop", c), pop, rr_pop_exp[c]);
            check($sformatf("rr%0d_push", c), push, rr_push_exp[c]);
            if (rr_push_exp[c] != 16'h0000)
                check($sformatf("rr%0d_dpush", c), d_push, rr_data_exp[c]);
        end
        pndng = 16'h0000;
        tick();
        tick();
        tick();

        // Reset during GRANT: no push follows, next grant restarts at device 0
        d_pop[5] = 16'h0111;
        pndng    = 16'h0020;
        tick();
        check("mid_pop", pop, 16'h0020);
        reset = 1'b1;
        pndng = 16'h0000;
        tick();
        check("mid_rst_push", push, 16'h0000);
        check("mid_rst_pop", pop, 16'h0000);
        check("mid_rst_dpush", d_push, 16'h0000);
        reset = 1'b0;
        tick();
        check("mid_after_push", push, 16'h0000);
        pndng = 16'hFFFF;
        tick();
        check("mid_regrant", pop, 16'h0001);
        pndng = 16'h0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/test_bus.md
# test_bus

Shared-bus interconnect for `DISPOSITIVOS` peripheral devices, each presenting a fall-through output FIFO head and accepting packets through a push port. It arbitrates pending senders round-robin and pops one packet at a time. It routes each packet by a destination ID in its top 8 bits, either to a single device or as a broadcast to every device except the sender. It is the device-under-test level of the bus verification environment.

## Interface
- `WIDTH`, 16, packet width in bits; must be ≥ 9.
- `DISPOSITIVOS`, 16, number of attached devices; 2..255.
- `BROADCAST`, 8'hFF, destination ID meaning "all devices except sender".
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pndng`  in  DISPOSITIVOS  bit i high = device i FIFO holds a packet.
- `D_pop`  in  DISPOSITIVOS×WIDTH  device i FIFO head data, valid while `pndng[i]` is high (fall-through).
- `pop`  out  DISPOSITIVOS  one-cycle pulse; removes the head of device i FIFO.
- `push`  out  DISPOSITIVOS  one-cycle pulse; writes `D_push` into device i input.
- `D_push`  out  WIDTH  packet being delivered; shared by all devices.

## Operation
- Packet format: bits [WIDTH-1:WIDTH-8] = destination ID; the remaining bits are payload, forwarded unmodified. The full word is delivered, including the ID.
- FSM states: IDLE, GRANT, DELIVER.
- IDLE
  - If any `pndng` bit is high, select the first set bit found searching upward from pointer `rr` with wrap-around.
  - Store the selection as `src` and go to GRANT; otherwise stay in IDLE.
- GRANT
  - Assert `pop[src]` for exactly one cycle.
  - Latch `D_pop[src]` into the data register.
  - Set `rr` = (`src`+1) mod DISPOSITIVOS.
  - Go to DELIVER.
- DELIVER
  - Drive `D_push` from the data register.
  - Destination < DISPOSITIVOS: assert `push[dst]` only. Delivery to `src` itself is allowed.
  - Destination == BROADCAST: assert every `push` bit except `push[src]`.
  - Any other ID: no push; the packet is silently dropped.
  - Go to IDLE.
- Only one packet is in flight at a time. `pndng` is ignored outside IDLE.
- `D_push` holds the last delivered value between transfers.

## Timing
- Reset (synchronous, any state)
  - All of `pop`, `push`, `D_push`, the data register and `src` are forced to 0.
  - `rr` = 0 and state = IDLE.
  - Reset asserted mid-transfer aborts the transfer with no further pop or push.
  - A packet popped before reset is lost.
- Latency: with `pndng` sampled high in IDLE at edge t:
  - `pop` is high during cycle t+1.
  - `push` and valid `D_push` are present during cycle t+2.
  - IDLE is re-entered at t+3.
- Throughput: one packet per 3 cycles when requests are continuous.
- `pop` and `push` are never asserted in the same cycle.
- No output is ever high for more than one consecutive cycle per packet.
- Fairness: with all `pndng` bits held high, grants proceed 0,1,2,…,DISPOSITIVOS-1,0,…
- Simultaneous requests are resolved by `rr` only; there is no fixed priority.

## Test plan
- Reset check: assert `reset` 2 cycles with `pndng`=all ones → `pop`=0, `push`=0, `D_push`=0; the first grant after release goes to device 0.
- Unicast: device 3 pending with `D_pop[3]`=16'h05AB → `pop[3]` one cycle later, then `push`=16'h0020 with `D_push`=16'h05AB; no other bits asserted.
- Broadcast: device 7 pending with 16'hFF12 → `push` = 16'hFF7F (all bits except bit 7) for one cycle, with `D_push`=16'hFF12.
- Invalid destination: device 2 sends 16'h2034 (ID 0x20 ≥ 16) → `pop[2]` pulses, `push` stays 0, FSM returns to IDLE.
- Round-robin: `pndng`=16'h8011 held, each FIFO with ≥ 2 packets → grant order 0,4,15,0,4,…, spaced exactly 3 cycles apart.
- Mid-transfer reset: assert `reset` in the GRANT cycle → no `push` follows; the next grant starts from device 0.
